sar_channel_ctrl: RTL

// Per-channel digital sequencer for one analog_channel of the analog core.

---
 rtl/larpix_ctrl_pkg.sv | 25 ++
 rtl/sync2.sv | 26 ++
 rtl/sar_channel_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/larpix_ctrl_pkg.sv
// Shared types and default timing for the per-channel analog sequencers.
package larpix_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        SAMPLE,
        CONVERT,
        DONE,
        RESET
    } sar_state_t;

    localparam int ADCBITS_DEF       = 8;
    localparam int HOLD_CYCLES_DEF   = 3;
    localparam int SAMPLE_CYCLES_DEF = 2;
    localparam int RESET_CYCLES_DEF  = 4;

    // Used to size a counter that is shared by several timed states.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the value from before the edge, regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/sar_channel_ctrl.sv
// Per-channel sequencer: trigger, hold, sample, SAR conversion, handshake, CSA reset.
module sar_channel_ctrl
    import larpix_ctrl_pkg::*;
#(
    parameter int ADCBITS       = ADCBITS_DEF,
    parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter int SAMPLE_CYCLES = SAMPLE_CYCLES_DEF,
    parameter int RESET_CYCLES  = RESET_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               hit,
    input  logic               ext_trig,
    input  logic               comp,
    output logic               sample,
    output logic               strobe,
    output logic               csa_reset,
    output logic [ADCBITS-1:0] dac_word,
    output logic [ADCBITS-1:0] adc_word,
    output logic               adc_valid,
    input  logic               adc_ready,
    output logic               trig_ext,
    output logic               hit_dropped
);

    localparam int CNT_W = $clog2(max3(HOLD_CYCLES, SAMPLE_CYCLES, RESET_CYCLES) + 1);
    localparam int BIT_W = (ADCBITS > 1) ? $clog2(ADCBITS) : 1;

    // The shared counter holds the number of cycles left in the current timed state.
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] SAMPLE_LOAD = CNT_W'(SAMPLE_CYCLES);
    localparam logic [CNT_W-1:0] RESET_LOAD  = CNT_W'(RESET_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(1);
    localparam logic [BIT_W-1:0] BIT_FIRST   = BIT_W'(ADCBITS - 1);

    sar_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic               phase_q, phase_d;
    logic [ADCBITS-1:0] result_q, result_d;
    logic [ADCBITS-1:0] adc_word_q, adc_word_d;
    logic               trig_ext_q, trig_ext_d;
    logic               hit_dropped_q, hit_dropped_d;
    logic               hit_s_q;
    logic               hit_s;
    logic [ADCBITS-1:0] trial;

    sync2 u_hit_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (hit),
        .q_o   (hit_s)
    );

    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_d         = bit_q;
        phase_d       = phase_q;
        result_d      = result_q;
        adc_word_d    = adc_word_q;
        trig_ext_d    = trig_ext_q;
        hit_dropped_d = hit_dropped_q;

        unique case (state_q)
            IDLE: begin
                if (ext_trig || (enable && hit_s)) begin
                    trig_ext_d = ext_trig;
                    if (HOLD_CYCLES == 0) begin
                        state_d = SAMPLE;
                        cnt_d   = SAMPLE_LOAD;
                    end else begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LOAD;
                    end
                end
            end
            HOLD: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = SAMPLE;
                    cnt_d   = SAMPLE_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SAMPLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d  = CONVERT;
                    bit_d    = BIT_FIRST;
                    phase_d  = 1'b0;
                    result_d = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CONVERT: begin
                // Phase A strobes the comparator; its decision is taken at the end of phase B.
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d         = 1'b0;
                    result_d[bit_q] = comp;
                    if (bit_q == '0) begin
                        adc_word_d = result_d;
                        state_d    = DONE;
                    end else begin
                        bit_d = bit_q - 1'b1;
                    end
                end
            end
            DONE: begin
                if (adc_ready) begin
                    state_d       = RESET;
                    cnt_d         = RESET_LOAD;
                    hit_dropped_d = 1'b0;
                end
            end
            RESET: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = RESET;
                cnt_d   = RESET_LOAD;
            end
        endcase

        // A new hit edge while busy is lost; the flag records it for the event builder.
        if ((state_q != IDLE) && enable && hit_s && !hit_s_q) begin
            hit_dropped_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RESET;
            cnt_q         <= RESET_LOAD;
            bit_q         <= '0;
            phase_q       <= 1'b0;
            result_q      <= '0;
            adc_word_q    <= '0;
            trig_ext_q    <= 1'b0;
            hit_dropped_q <= 1'b0;
            hit_s_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_q         <= bit_d;
            phase_q       <= phase_d;
            result_q      <= result_d;
            adc_word_q    <= adc_word_d;
            trig_ext_q    <= trig_ext_d;
            hit_dropped_q <= hit_dropped_d;
            hit_s_q       <= hit_s;
        end
    end

    always_comb begin
        trial        = '0;
        trial[bit_q] = 1'b1;
    end

    assign dac_word    = (state_q == CONVERT) ? (result_q | trial) : '0;
    assign strobe      = (state_q == CONVERT) && !phase_q;
    assign sample      = (state_q == SAMPLE);
    assign csa_reset   = (state_q == RESET);
    assign adc_valid   = (state_q == DONE);
    assign adc_word    = adc_word_q;
    assign trig_ext    = trig_ext_q;
    assign hit_dropped = hit_dropped_q;

endmodule
